shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one `barrel_shifter` instance (32-bit data, 5-bit amount, 1-cycle registered latency) between N_REQ requesters.
- Each requester has a valid/ready request channel. A single valid/ready response channel returns results tagged with the requester id.
- Arbitration is round-robin. At most one operation is in flight; the shifter inputs are held stable so its output stays valid until the response is accepted.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), localparam; width of the response tag.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  N_REQ  per-requester request valid.
- o_req_ready  out  N_REQ  per-requester request accepted; one-hot or zero.
- i_req_signed  in  N_REQ  per-requester arithmetic right-shift select.
- i_req_left  in  N_REQ  per-requester left-shift select; overrides signed.
- i_req_amt  in  5*N_REQ  shift amounts; requester k uses bits [5k+4:5k].
- i_req_data  in  32*N_REQ  operands; requester k uses bits [32k+31:32k].
- o_rsp_valid  out  1  result valid.
- i_rsp_ready  in  1  consumer accepts result.
- o_rsp_id  out  ID_W  index of the requester that owns the result.
- o_rsp_data  out  32  shifted result.
- o_busy  out  1  high when state is not IDLE.

Behaviour:
- **Reset:** state=IDLE; o_rsp_valid=0; o_rsp_id=0; rr pointer=0; hold regs (signed, left, amt, data) all 0; o_busy=0.
- **Reset mid-operation:** the in-flight operation is discarded; no response is produced.
- **States:**
  - IDLE: no op in flight.
  - SHIFT: hold regs loaded; shifter computing.
  - RESP: o_rsp_valid=1.
- **Transitions:**
  - IDLE -> SHIFT on grant.
  - SHIFT -> RESP unconditionally, after exactly one cycle.
  - RESP -> IDLE on i_rsp_ready with no grant.
  - RESP -> SHIFT on i_rsp_ready with a grant (back-to-back).
  - RESP holds while i_rsp_ready=0.
- **Grant enable:** grant_en = (state==IDLE) | (state==RESP & i_rsp_ready). It is combinational from i_rsp_ready; no path from i_req_* to o_rsp_*.
- **Arbitration:**
  - Grant goes to the first k with i_req_valid[k]=1, searching from rr pointer upward and wrapping modulo N_REQ.
  - o_req_ready[k]=1 only for the granted k while grant_en=1. Handshake = i_req_valid[k] & o_req_ready[k].
  - On a grant to k, rr pointer <= (k+1) mod N_REQ. The pointer is unchanged otherwise.
- **Issue:** on a handshake in cycle t, the hold regs load the request fields and o_rsp_id loads k at the edge ending t. The shifter's inputs are wired to the hold regs only.
- **Latency:** the shifter output updates at the edge ending t+1. o_rsp_valid=1 from cycle t+2 until accepted.
- **Throughput:** one op per 2 cycles maximum.
- **Stability:** o_rsp_data is driven directly from the shifter output. It stays stable because the hold regs change only on a handshake. o_rsp_id and o_rsp_data are stable while o_rsp_valid & ~i_rsp_ready.
- **Request stability:** requesters must keep fields stable while valid and not ready. A requester that drops valid before its grant forfeits its slot; this is not an error.
- **Shift semantics (from the shifter):**
  - left=1: logical left shift, zero fill.
  - left=0, signed=1: arithmetic right shift.
  - left=0, signed=0: logical right shift.
  - amt=0: data passes unchanged.
- **Boundaries:**
  - All requesters valid: strict rotation 0,1,2,3,0,...
  - A single requester valid continuously: it is served every op.
  - Response stalled indefinitely: no further grants; all o_req_ready=0.
- o_busy = (state != IDLE).

Decomposition:
- shifter_pkg:
  - constants DATA_W=32, AMT_W=5.
  - typedef shift_req_t (signed, left, amt[AMT_W-1:0], data[DATA_W-1:0]).
  - typedef enum state_t {IDLE, SHIFT, RESP}.
- Sub-module: one `barrel_shifter` instance, u_shifter, clocked by i_clk.
- The round-robin picker is an internal function, not a separate module.

Test Plan:
- Reset, then req0 sends data 0x8000_0000, amt 4, logical right -> o_rsp_valid exactly 2 cycles after the handshake, id 0, data 0x0800_0000. The same request with signed=1 -> 0xF800_0000.
- req2 sends data 0x0000_0001, amt 31, left (signed=1 also set) -> id 2, data 0x8000_0000. amt 0 with 0x1234_5678 -> 0x1234_5678.
- All 4 requesters valid continuously with i_rsp_ready=1 -> grants 0,1,2,3,0,1; a new response every 2 cycles; ids match; rr wraps after 3.
- Hold i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid, id and data stable; o_req_ready all 0. Raise i_rsp_ready with req1 valid -> same-cycle grant to req1 (RESP->SHIFT); next response 2 cycles later.
- Assert i_rst in SHIFT and again in RESP -> next cycle o_rsp_valid=0, o_busy=0, rr=0; no stale response appears afterward.
- req3 valid only, with rr pointer at 0 -> req3 granted; rr becomes 0 (wrap); a following simultaneous req0+req3 grants req0 first.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the shift arbiter and its barrel shifter.
// Holds the datapath widths, the request bundle and the arbiter FSM states.
// No logic lives here.
package shifter_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  typedef struct packed {
    logic              sgn;
    logic              left;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] data;
  } shift_req_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_t;

endpackage

// File: rtl/barrel_shifter.sv
// Barrel shifter: logical left, logical right or arithmetic right by 0..31.
// Latency: 1 cycle, output registered.
// Backpressure: none; the caller holds the operands stable to hold the result.
module barrel_shifter
  import shifter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  shift_req_t        op,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = op.data >> op.amt;
    if (op.left) begin
      shifted = op.data << op.amt;
    end else if (op.sgn) begin
      shifted = $signed(op.data) >>> op.amt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result <= '0;
    end else begin
      result <= shifted;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among N_REQ requesters.
// Latency: response valid 2 cycles after the request handshake; one op per 2 cycles.
// Backpressure: a stalled response blocks all grants until it is accepted.
module shift_arbiter
  import shifter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic [N_REQ-1:0]        i_req_signed,
  input  logic [N_REQ-1:0]        i_req_left,
  input  logic [AMT_W*N_REQ-1:0]  i_req_amt,
  input  logic [DATA_W*N_REQ-1:0] i_req_data,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic                    o_busy
);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, rr_nxt;
  logic [ID_W-1:0] grant_id;
  logic            grant_found, grant_en, grant;
  shift_req_t      hold, req_sel;

  // First valid requester at or after ptr, wrapping; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   pick;
    logic [ID_W-1:0] idx;
    pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (!pick[ID_W] && vld[idx]) begin
        pick = {1'b1, idx};
      end
    end
    return pick;
  endfunction

  always_comb begin
    {grant_found, grant_id} = rr_pick(i_req_valid, rr_ptr);
    grant_en = (state == IDLE) || ((state == RESP) && i_rsp_ready);
    grant    = grant_en && grant_found;
    o_req_ready = '0;
    if (grant) begin
      o_req_ready[grant_id] = 1'b1;
    end
    rr_nxt = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    req_sel.sgn  = i_req_signed[grant_id];
    req_sel.left = i_req_left[grant_id];
    req_sel.amt  = i_req_amt[grant_id*AMT_W +: AMT_W];
    req_sel.data = i_req_data[grant_id*DATA_W +: DATA_W];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = SHIFT;
      SHIFT:   state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = grant ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold     <= '0;
      o_rsp_id <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        hold     <= req_sel;
        rr_ptr   <= rr_nxt;
        o_rsp_id <= grant_id;
      end
    end
  end

  // Operands come only from the hold regs, so the result stays put while stalled.
  barrel_shifter u_shifter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .op     (hold),
    .result (o_rsp_data)
  );

  assign o_rsp_valid = (state == RESP);
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus random traffic against a
// transaction-level model (one op slot, age counter, rotating priority).
module tb_shift_arbiter;

  localparam int N = 4;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    req_valid, req_ready, req_signed, req_left;
  logic [5*N-1:0]  req_amt;
  logic [32*N-1:0] req_data;
  logic            rsp_valid, rsp_ready, busy;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_data;

  shift_arbiter #(.N_REQ(N)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_signed (req_signed),
    .i_req_left   (req_left),
    .i_req_amt    (req_amt),
    .i_req_data   (req_data),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state: one op slot, its age in cycles since issue, rotating priority.
  int          m_rr   = 0;
  bit          m_pend = 0;
  int          m_age  = 0;
  int          m_id   = 0;
  logic [31:0] m_data = '0;

  bit          s_rst, s_rv, s_acc, s_g;
  int          s_gk;
  logic [31:0] s_gdata;
  bit          keep_valid = 0;
  bit          rand_mode  = 0;

  int          obs_grants[$];
  int          obs_id[$];
  logic [31:0] obs_data[$];

  function automatic logic [31:0] ref_shift(bit sgn, bit left, int a, logic [31:0] d);
    logic [31:0] r;
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    if (left) begin
      r = d << a;
    end else begin
      r = d >> a;
      if (sgn && d[31] && a != 0) r = r | ~(ones >> a);
    end
    return r;
  endfunction

  task automatic set_req(input int k, input bit s, input bit l, input logic [4:0] a,
                         input logic [31:0] d);
    req_valid[k]      = 1'b1;
    req_signed[k]     = s;
    req_left[k]       = l;
    req_amt[5*k +: 5]   = a;
    req_data[32*k +: 32] = d;
  endtask

  task automatic check_phase();
    bit       ge;
    int       idx;
    logic [3:0] exp_rdy;
    s_rst = i_rst;
    s_rv  = m_pend && (m_age >= 1);
    s_acc = s_rv && rsp_ready;
    ge    = !m_pend || s_acc;
    s_g   = 0;
    s_gk  = 0;
    if (ge) begin
      for (int i = 0; i < N; i++) begin
        idx = (m_rr + i) % N;
        if (!s_g && req_valid[idx]) begin
          s_g  = 1;
          s_gk = idx;
        end
      end
    end
    exp_rdy = s_g ? 4'(1 << s_gk) : 4'b0;
    if (s_g) s_gdata = ref_shift(req_signed[s_gk], req_left[s_gk],
                                 int'(req_amt[5*s_gk +: 5]), req_data[32*s_gk +: 32]);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(s_rv));
    check("busy", 32'(busy), 32'(m_pend));
    if (s_rv) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_data", rsp_data, m_data);
    end
    for (int k = 0; k < N; k++) if (req_ready[k]) obs_grants.push_back(k);
    if (rsp_valid && rsp_ready) begin
      obs_id.push_back(int'(rsp_id));
      obs_data.push_back(rsp_data);
    end
  endtask

  task automatic update_phase();
    if (s_rst) begin
      m_pend = 0;
      m_rr   = 0;
      m_age  = 0;
    end else begin
      if (s_acc) m_pend = 0;
      if (s_g) begin
        m_pend = 1;
        m_age  = 0;
        m_id   = s_gk;
        m_data = s_gdata;
        m_rr   = (s_gk + 1) % N;
        if (!keep_valid) req_valid[s_gk] = 1'b0;
      end else if (m_pend) begin
        m_age++;
      end
    end
    if (rand_mode) begin
      rsp_ready = ($urandom % 4) != 0;
      i_rst     = ($urandom % 150) == 0;
      for (int k = 0; k < N; k++)
        if (!req_valid[k] && ($urandom % 3) == 0)
          set_req(k, 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
    end
  endtask

  task automatic cycle();
    @(negedge i_clk);
    check_phase();
    @(posedge i_clk);
    #1;
    update_phase();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic expect_rsp(input string tag, input int id, input logic [31:0] data);
    check({tag, "_count"}, 32'(obs_data.size()), 32'd1);
    if (obs_data.size() > 0) begin
      check({tag, "_id"}, 32'(obs_id.pop_front()), 32'(id));
      check({tag, "_data"}, obs_data.pop_front(), data);
    end
    obs_data.delete();
    obs_id.delete();
  endtask

  task automatic expect_grants(input string tag, input int exp[$]);
    check({tag, "_count"}, 32'(obs_grants.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs_grants.size(); i++)
      check(tag, 32'(obs_grants[i]), 32'(exp[i]));
    obs_grants.delete();
  endtask

  initial begin
    i_rst      = 1'b1;
    req_valid  = '0;
    req_signed = '0;
    req_left   = '0;
    req_amt    = '0;
    req_data   = '0;
    rsp_ready  = 1'b1;
    run(2);
    i_rst = 1'b0;
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_data", rsp_data, 32'd0);

    // Single ops: logical right, arithmetic right, left, zero amount.
    set_req(0, 1'b0, 1'b0, 5'd4, 32'h8000_0000);
    run(4);
    expect_rsp("lsr", 0, 32'h0800_0000);
    set_req(0, 1'b1, 1'b0, 5'd4, 32'h8000_0000);
    run(4);
    expect_rsp("asr", 0, 32'hF800_0000);
    set_req(2, 1'b1, 1'b1, 5'd31, 32'h0000_0001);
    run(4);
    expect_rsp("lsl", 2, 32'h8000_0000);
    set_req(1, 1'b0, 1'b0, 5'd0, 32'h1234_5678);
    run(4);
    expect_rsp("amt0", 1, 32'h1234_5678);

    // All requesters continuously valid: strict rotation.
    i_rst = 1'b1;
    run(1);
    i_rst = 1'b0;
    obs_grants.delete();
    keep_valid = 1;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b1, 5'(k + 1), 32'h0000_0100 << k);
    run(12);
    keep_valid = 0;
    req_valid  = '0;
    expect_grants("rotate", '{0, 1, 2, 3, 0, 1});
    run(3);
    obs_data.delete();
    obs_id.delete();

    // Stalled response, then a same-cycle regrant on release.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 5'd8, 32'h8000_1234);
    run(3);
    run(3);
    set_req(1, 1'b0, 1'b1, 5'd3, 32'h0000_0011);
    run(2);
    expect_grants("stall", '{0});
    rsp_ready = 1'b1;
    run(1);
    expect_grants("release", '{1});
    run(3);
    obs_data.delete();
    obs_id.delete();

    // Reset while in SHIFT and while in RESP: no stale response afterwards.
    set_req(3, 1'b0, 1'b0, 5'd1, 32'h0000_0F00);
    run(1);
    i_rst = 1'b1;
    run(1);
    i_rst = 1'b0;
    run(4);
    rsp_ready = 1'b0;
    set_req(2, 1'b0, 1'b0, 5'd2, 32'h0000_0F00);
    run(2);
    i_rst = 1'b1;
    run(1);
    i_rst = 1'b0;
    rsp_ready = 1'b1;
    run(4);
    check("rst_no_rsp", 32'(obs_data.size()), 32'd0);
    obs_grants.delete();

    // Pointer wrap: req3 alone from rr=0, then req0+req3 together.
    set_req(3, 1'b0, 1'b1, 5'd1, 32'h0000_0003);
    run(1);
    set_req(0, 1'b0, 1'b0, 5'd1, 32'h0000_0006);
    set_req(3, 1'b1, 1'b0, 5'd1, 32'h8000_0000);
    run(6);
    expect_grants("wrap", '{3, 0, 3});
    obs_data.delete();
    obs_id.delete();

    // Random traffic with random backpressure and occasional reset.
    rand_mode = 1;
    run(3000);
    rand_mode = 0;
    i_rst     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
